// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the dmem load/store unit: RV32I width codes,
// FSM state encoding, byte-enable masks and the request legality check.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] WEA_NONE = 4'b0000;
    localparam logic [3:0] WEA_B0   = 4'b0001;
    localparam logic [3:0] WEA_HLO  = 4'b0011;
    localparam logic [3:0] WEA_HHI  = 4'b1100;
    localparam logic [3:0] WEA_W    = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDDATA,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_e;

    // Alignment and width-code legality; the region check lives in the top
    // because it depends on the instance parameters.
    function automatic logic access_illegal(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (funct3)
                F3_B:    bad = 1'b0;
                F3_H:    bad = addr_lo[0];
                F3_W:    bad = |addr_lo;
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: bad = 1'b0;
                F3_H, F3_HU: bad = addr_lo[0];
                F3_W:        bad = |addr_lo;
                default:     bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: picks the byte/half addressed by addr_lo out of the
// dmem read word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] doutb,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = doutb[7:0];
            2'd1:    byte_sel = doutb[15:8];
            2'd2:    byte_sel = doutb[23:16];
            default: byte_sel = doutb[31:24];
        endcase
        half_sel = addr_lo[1] ? doutb[31:16] : doutb[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            default: rdata = doutb;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// CPU-side load/store master for the dual-port data memory: one request at a
// time, partial stores use the two-edge read-merge-write contract of dmem.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int          ADDR_W    = 15,
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [31:0]       mem_dina,
    output logic              mem_ena,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              mem_enb,
    input  logic [31:0]       mem_doutb
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_q;
    logic [1:0]          lo_q;
    logic [2:0]          funct3_q;
    logic [31:0]         wdata_q;
    logic                err_q;

    logic                accept;
    logic                in_region;
    logic                req_err;
    logic [31:0]         load_rdata;
    logic [31:0]         store_dina;
    logic [3:0]          store_wea;

    assign req_ready = rstn && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_region = (req_addr[31:ADDR_W+2] == DMEM_BASE[31:ADDR_W+2]);
    assign req_err   = !in_region || access_illegal(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            lo_q     <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_q   <= req_addr[ADDR_W+1:2];
                lo_q     <= req_addr[1:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
        end
    end

    // Full-word stores skip WR1: dmem commits them on a single edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                 state_d = ST_DONE;
                    else if (!req_we)            state_d = ST_RD;
                    else if (req_funct3 == F3_W) state_d = ST_WR2;
                    else                         state_d = ST_WR1;
                end
            end
            ST_RD:     state_d = ST_RDDATA;
            ST_RDDATA: state_d = ST_IDLE;
            ST_WR1:    state_d = ST_WR2;
            ST_WR2:    state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (funct3_q)
            F3_B: begin
                store_dina = {4{wdata_q[7:0]}};
                store_wea  = WEA_B0 << lo_q;
            end
            F3_H: begin
                store_dina = {2{wdata_q[15:0]}};
                store_wea  = lo_q[1] ? WEA_HHI : WEA_HLO;
            end
            default: begin
                store_dina = wdata_q;
                store_wea  = WEA_W;
            end
        endcase
    end

    lsu_load_align u_align (
        .funct3  (funct3_q),
        .addr_lo (lo_q),
        .doutb   (mem_doutb),
        .rdata   (load_rdata)
    );

    // Every mem_* output is forced to zero outside the state that owns it.
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addra  = '0;
        mem_dina   = '0;
        mem_ena    = 1'b0;
        mem_wea    = WEA_NONE;
        mem_addrb  = '0;
        mem_enb    = 1'b0;
        case (state_q)
            ST_RD: begin
                mem_enb   = 1'b1;
                mem_addrb = word_q;
            end
            ST_RDDATA: begin
                resp_valid = 1'b1;
                resp_rdata = load_rdata;
            end
            ST_WR1, ST_WR2: begin
                mem_ena   = 1'b1;
                mem_addra = word_q;
                mem_dina  = store_dina;
                mem_wea   = store_wea;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: behavioural dmem, directed vector table,
// reset-abort sequences and a random request stream against a shadow memory.
module tb_dmem_lsu;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addra;
    logic [31:0]       mem_dina;
    logic              mem_ena;
    logic [3:0]        mem_wea;
    logic [ADDR_W-1:0] mem_addrb;
    logic              mem_enb;
    logic [31:0]       mem_doutb;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(ADDR_W), .DMEM_BASE(32'h0010_0000)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_ena(mem_ena),
        .mem_wea(mem_wea), .mem_addrb(mem_addrb), .mem_enb(mem_enb),
        .mem_doutb(mem_doutb)
    );

    typedef struct {
        int          id;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_ena;
        int          n_enb;
        logic [3:0]  wea;
        logic [31:0] dina;
        logic [31:0] maddr;
    } vec_t;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    vec_t sb_q[$];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // dmem: registered read, full-word write in one edge, partial write needs
    // the same command on two consecutive edges (capture old, then commit).
    logic [31:0]       mem [0:32767];
    logic              mem_init_q = 1'b0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_din, pend_old;
    logic [3:0]        pend_wea;

    always @(posedge clk) begin
        if (!mem_init_q) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 32'h0;
            mem_init_q <= 1'b1;
            pend       <= 1'b0;
        end else begin
            if (mem_ena) begin
                if (mem_wea == 4'hF) begin
                    mem[mem_addra] <= mem_dina;
                    pend <= 1'b0;
                end else if (pend && pend_addr == mem_addra && pend_din == mem_dina && pend_wea == mem_wea) begin
                    mem[mem_addra] <= merge(pend_old, mem_dina, mem_wea);
                    pend <= 1'b0;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= mem_addra;
                    pend_din  <= mem_dina;
                    pend_wea  <= mem_wea;
                    pend_old  <= mem[mem_addra];
                end
            end else begin
                pend <= 1'b0;
            end
            if (mem_enb && !mem_ena) mem_doutb <= mem[mem_addrb];
        end
    end

    logic hs_seen = 1'b0;
    always @(posedge clk) hs_seen <= req_valid && req_ready;

    // Monitor: per-cycle protocol invariants and scoreboard pop on resp_valid.
    logic        inflight = 1'b0;
    int          cyc, n_ena, n_enb;
    logic [3:0]  r_wea;
    logic [31:0] r_dina, r_addr;
    logic        hold_bad;
    vec_t        mon_e;

    always @(negedge clk) begin
        chk("ena_enb_exclusive", -1, {31'b0, mem_ena & mem_enb}, 32'h0);
        if (!mem_ena) chk("wport_zero", -1, {29'b0, |mem_addra, |mem_dina, |mem_wea}, 32'h0);
        if (!mem_enb) chk("rport_zero", -1, {31'b0, |mem_addrb}, 32'h0);
        if (!rstn) begin
            chk("ready_in_reset", -1, {31'b0, req_ready}, 32'h0);
            inflight = 1'b0;
        end else begin
            if (hs_seen) begin
                inflight = 1'b1;
                cyc = 0; n_ena = 0; n_enb = 0;
                r_wea = '0; r_dina = '0; r_addr = '0; hold_bad = 1'b0;
            end
            if (inflight) begin
                cyc++;
                chk("ready_when_busy", -1, {31'b0, req_ready}, 32'h0);
                if (mem_ena) begin
                    if (n_ena > 0 && (r_wea != mem_wea || r_dina != mem_dina || r_addr != 32'(mem_addra)))
                        hold_bad = 1'b1;
                    n_ena++;
                    r_wea = mem_wea; r_dina = mem_dina; r_addr = 32'(mem_addra);
                end
                if (mem_enb) begin
                    n_enb++;
                    r_addr = 32'(mem_addrb);
                end
                if (resp_valid) begin
                    inflight = 1'b0;
                    if (sb_q.size() == 0) begin
                        chk("resp_unexpected", -1, 32'h1, 32'h0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("rdata",      mon_e.id, resp_rdata, mon_e.rdata);
                        chk("err",        mon_e.id, {31'b0, resp_err}, {31'b0, mon_e.err});
                        chk("latency",    mon_e.id, 32'(cyc), 32'(mon_e.lat));
                        chk("ena_cycles", mon_e.id, 32'(n_ena), 32'(mon_e.n_ena));
                        chk("enb_cycles", mon_e.id, 32'(n_enb), 32'(mon_e.n_enb));
                        chk("wea",        mon_e.id, {28'b0, r_wea}, {28'b0, mon_e.wea});
                        chk("dina",       mon_e.id, r_dina, mon_e.dina);
                        chk("mem_addr",   mon_e.id, r_addr, mon_e.maddr);
                        chk("wport_hold", mon_e.id, {31'b0, hold_bad}, 32'h0);
                        $display("txn %0d we=%0d f3=%0d addr=%h rdata=%h err=%0d lat=%0d",
                                 mon_e.id, mon_e.we, mon_e.f3, mon_e.addr, resp_rdata, resp_err, cyc);
                    end
                end else if (cyc > 8) begin
                    inflight = 1'b0;
                    chk("resp_timeout", -1, 32'(cyc), 32'h0);
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                end
            end else begin
                chk("stray_resp", -1, {31'b0, resp_valid}, 32'h0);
                chk("ready_when_idle", -1, {31'b0, req_ready}, 32'h1);
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                                input int lat, input int n_ena, input int n_enb, input logic [3:0] wea,
                                input logic [31:0] dina, input logic [31:0] maddr);
        vec_t v;
        v.id = 0; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.n_ena = n_ena; v.n_enb = n_enb; v.wea = wea;
        v.dina = dina; v.maddr = maddr;
        return v;
    endfunction

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) return;
        end
        chk("drain_timeout", -1, 32'(sb_q.size()), 32'h0);
        sb_q.delete();
    endtask

    // Returns #1 after the handshake edge, with garbage left on req_* to show
    // that the block ignores them while busy.
    task automatic issue(input vec_t v, input bit push);
        if (push) sb_q.push_back(v);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (hs_seen) begin
                req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                return;
            end
        end
        chk("handshake_timeout", v.id, 32'h1, 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "no handshake");
    endtask

    logic [31:0] ref_mem [0:31];

    task automatic rand_txn(input int id);
        vec_t        v;
        logic        we, bad;
        logic [2:0]  f3;
        logic [31:0] addr, wd, w, sh;
        we   = 1'($urandom);
        f3   = 3'($urandom);
        addr = 32'h0010_0040 + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) addr = addr ^ 32'h0100_0000;
        wd   = $urandom;
        bad  = (addr[31:17] != 15'h8);
        if (we) bad = bad || (f3 > 3'd2) || (f3 == 3'd1 && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
        else    bad = bad || (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
                      ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
        v = mk(we, f3, addr, wd, 32'h0, bad, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        v.id = id;
        if (!bad) begin
            v.maddr = {17'b0, addr[16:2]};
            w = ref_mem[addr[6:2]];
            sh = {27'b0, addr[1:0], 3'b0};
            if (!we) begin
                v.lat = 2; v.n_enb = 1;
                case (f3)
                    3'd0: v.rdata = {{24{w[sh+7]}}, 8'(w >> sh)};
                    3'd4: v.rdata = {24'h0, 8'(w >> sh)};
                    3'd1: v.rdata = {{16{w[sh+15]}}, 16'(w >> sh)};
                    3'd5: v.rdata = {16'h0, 16'(w >> sh)};
                    default: v.rdata = w;
                endcase
            end else begin
                case (f3)
                    3'd0: begin v.dina = {4{wd[7:0]}};  v.wea = 4'b0001 << addr[1:0]; end
                    3'd1: begin v.dina = {2{wd[15:0]}}; v.wea = addr[1] ? 4'b1100 : 4'b0011; end
                    default: begin v.dina = wd; v.wea = 4'b1111; end
                endcase
                v.lat   = (f3 == 3'd2) ? 2 : 3;
                v.n_ena = (f3 == 3'd2) ? 1 : 2;
                ref_mem[addr[6:2]] = merge(w, v.dina, v.wea);
            end
        end
        wait_done();
        issue(v, 1'b1);
    endtask

    vec_t vecs[22];
    vec_t v;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

        //             we  f3    addr          wdata         rdata        err lat ena enb wea   dina          maddr
        vecs[0]  = mk(1, 3'd2, 32'h0010_0008, 32'hDEADBEEF, 32'h0,        0, 2, 1, 0, 4'hF, 32'hDEADBEEF, 32'd2);
        vecs[1]  = mk(0, 3'd2, 32'h0010_0008, 32'h0,        32'hDEADBEEF, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[2]  = mk(1, 3'd0, 32'h0010_0009, 32'hAB12CD55, 32'h0,        0, 3, 2, 0, 4'h2, 32'h55555555, 32'd2);
        vecs[3]  = mk(0, 3'd2, 32'h0010_0008, 32'h0,        32'hDEAD55EF, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[4]  = mk(0, 3'd0, 32'h0010_0009, 32'h0,        32'h00000055, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[5]  = mk(0, 3'd4, 32'h0010_000B, 32'h0,        32'h000000DE, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[6]  = mk(0, 3'd0, 32'h0010_000B, 32'h0,        32'hFFFFFFDE, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[7]  = mk(1, 3'd1, 32'h0010_000A, 32'hFFFF8001, 32'h0,        0, 3, 2, 0, 4'hC, 32'h80018001, 32'd2);
        vecs[8]  = mk(0, 3'd1, 32'h0010_000A, 32'h0,        32'hFFFF8001, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[9]  = mk(0, 3'd5, 32'h0010_000A, 32'h0,        32'h00008001, 0, 2, 0, 1, 4'h0, 32'h0,        32'd2);
        vecs[10] = mk(1, 3'd1, 32'h0010_0010, 32'h0000ABCD, 32'h0,        0, 3, 2, 0, 4'h3, 32'hABCDABCD, 32'd4);
        vecs[11] = mk(0, 3'd2, 32'h0010_0010, 32'h0,        32'h0000ABCD, 0, 2, 0, 1, 4'h0, 32'h0,        32'd4);
        vecs[12] = mk(0, 3'd0, 32'h0010_0011, 32'h0,        32'hFFFFFFAB, 0, 2, 0, 1, 4'h0, 32'h0,        32'd4);
        vecs[13] = mk(1, 3'd0, 32'h0011_FFFF, 32'h00000077, 32'h0,        0, 3, 2, 0, 4'h8, 32'h77777777, 32'h7FFF);
        vecs[14] = mk(0, 3'd4, 32'h0011_FFFF, 32'h0,        32'h00000077, 0, 2, 0, 1, 4'h0, 32'h0,        32'h7FFF);
        vecs[15] = mk(0, 3'd2, 32'h0012_0000, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[16] = mk(0, 3'd2, 32'h0010_0006, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[17] = mk(1, 3'd1, 32'h0010_0003, 32'h1234,     32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[18] = mk(0, 3'd0, 32'h0020_0000, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[19] = mk(0, 3'd3, 32'h0010_0008, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[20] = mk(1, 3'd3, 32'h0010_0008, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);
        vecs[21] = mk(0, 3'd7, 32'h0010_0008, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0,        32'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_resp_valid", -1, {31'b0, resp_valid}, 32'h0);
        chk("reset_mem_en",     -1, {30'b0, mem_ena, mem_enb}, 32'h0);
        chk("reset_rdata_err",  -1, resp_rdata | {31'b0, resp_err}, 32'h0);
        chk("reset_req_ready",  -1, {31'b0, req_ready}, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            vecs[i].id = i;
            wait_done();
            issue(vecs[i], 1'b1);
        end

        // Reset while in WR1: dmem saw only the capture edge, word unchanged.
        wait_done();
        v = mk(1, 3'd0, 32'h0010_0008, 32'h000000AA, 32'h0, 0, 3, 2, 0, 4'h1, 32'hAAAAAAAA, 32'd2);
        v.id = 50;
        issue(v, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
        v = mk(0, 3'd2, 32'h0010_0008, 32'h0, 32'h800155EF, 0, 2, 0, 1, 4'h0, 32'h0, 32'd2);
        v.id = 51;
        wait_done();
        issue(v, 1'b1);

        // Reset coinciding with the WR2 edge: the byte still commits.
        wait_done();
        v = mk(1, 3'd0, 32'h0010_0008, 32'h000000AA, 32'h0, 0, 3, 2, 0, 4'h1, 32'hAAAAAAAA, 32'd2);
        v.id = 52;
        issue(v, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rstn = 1'b1;
        v = mk(0, 3'd2, 32'h0010_0008, 32'h0, 32'h800155AA, 0, 2, 0, 1, 4'h0, 32'h0, 32'd2);
        v.id = 53;
        wait_done();
        issue(v, 1'b1);

        for (int k = 0; k < 40; k++) rand_txn(100 + k);

        wait_done();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
